// File: rtl/vga_pixel_capture.sv
// vga_pixel_capture: rebuilds adapter-pixel records (x, y, colour) from a sampled VGA stream.
// Define CAPTURE_CRC_EN to add a CRC-16-CCITT of each frame's px_rgb stream on frame_crc.
module vga_pixel_capture #(
  parameter int H_ACTIVE = 640,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_BP     = 33,
  parameter int SCALE    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vga_clk,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  output logic        px_valid,
  output logic [7:0]  px_x,
  output logic [6:0]  px_y,
  output logic [23:0] px_rgb,
  output logic        frame_start,
  output logic        frame_done,
  output logic        sync_err,
  output logic [15:0] frame_crc
);

  localparam int          SHIFT   = $clog2(SCALE);
  localparam logic [10:0] H_START = 11'(H_BP);
  localparam logic [10:0] H_END   = 11'(H_BP + H_ACTIVE);
  localparam logic [10:0] H_LAST  = 11'(H_ACTIVE - SCALE);
  localparam logic [9:0]  V_START = 10'(V_BP);
  localparam logic [9:0]  V_END   = 10'(V_BP + V_ACTIVE);
  localparam logic [9:0]  V_LAST  = 10'(V_ACTIVE - SCALE);
  localparam logic [10:0] H_MASK  = 11'(SCALE - 1);
  localparam logic [9:0]  V_MASK  = 10'(SCALE - 1);

  typedef enum logic [1:0] {SEEK, VSYNC, LINES} state_t;

  state_t      state, state_nxt;
  logic        vga_clk_q, hs_q, vs_q;
  logic        sample, hs_rise, vs_fall, vs_rise;
  logic [10:0] hcnt, hcnt_nxt, hoff;
  logic [9:0]  line, line_nxt, voff;
  logic        armed, armed_nxt;
  logic        frame_err, frame_err_nxt, err_set;
  logic        capture, origin, last, done_arm;

  // Sync edges compare against the levels seen at the previous sample event.
  assign sample  = vga_clk & ~vga_clk_q;
  assign hs_rise = sample & vga_hs & ~hs_q;
  assign vs_fall = sample & ~vga_vs & vs_q;
  assign vs_rise = sample & vga_vs & ~vs_q;
  assign hoff    = hcnt_nxt - H_START;
  assign voff    = line_nxt - V_START;
  assign origin  = (hoff == '0) && (voff == '0);
  assign last    = (hoff == H_LAST) && (voff == V_LAST);

  always_comb begin
    state_nxt     = state;
    hcnt_nxt      = hcnt;
    line_nxt      = line;
    armed_nxt     = armed;
    frame_err_nxt = frame_err;
    err_set       = 1'b0;
    capture       = 1'b0;
    case (state)
      SEEK: if (vs_fall) state_nxt = VSYNC;
      VSYNC: begin
        if (vs_rise) begin
          state_nxt     = LINES;
          hcnt_nxt      = '0;
          line_nxt      = '0;
          armed_nxt     = 1'b1;
          frame_err_nxt = 1'b0;
        end
      end
      LINES: begin
        // A VS fall wins over a coincident HS rise, which is then dropped.
        if (vs_fall) begin
          state_nxt = VSYNC;
          if (line < V_END) err_set = 1'b1;
        end else if (sample) begin
          if (hs_rise) begin
            if (!armed && line >= V_START && line < V_END && hcnt < H_END) err_set = 1'b1;
            hcnt_nxt = '0;
            if (armed) armed_nxt = 1'b0;
            else if (line != '1) line_nxt = line + 10'd1;
          end else if (hcnt != '1) begin
            hcnt_nxt = hcnt + 11'd1;
          end
          capture = !armed_nxt && hcnt_nxt != '1 && line_nxt != '1 &&
                    hcnt_nxt >= H_START && hcnt_nxt < H_END &&
                    line_nxt >= V_START && line_nxt < V_END &&
                    (hoff & H_MASK) == '0 && (voff & V_MASK) == '0;
        end
      end
      default: state_nxt = SEEK;
    endcase
    if (err_set) frame_err_nxt = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SEEK;
      vga_clk_q <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      hcnt      <= '0;
      line      <= '0;
      armed     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      vga_clk_q <= vga_clk;
      if (sample) begin
        hs_q <= vga_hs;
        vs_q <= vga_vs;
      end
      state     <= state_nxt;
      hcnt      <= hcnt_nxt;
      line      <= line_nxt;
      armed     <= armed_nxt;
      frame_err <= frame_err_nxt;
    end
  end

  // frame_done trails the last pixel by one clk and is withheld for frames with a sync error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      px_valid    <= 1'b0;
      px_x        <= '0;
      px_y        <= '0;
      px_rgb      <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      done_arm    <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      px_valid    <= capture;
      frame_start <= capture & origin;
      done_arm    <= capture & last & ~frame_err_nxt;
      frame_done  <= done_arm;
      sync_err    <= sync_err | err_set;
      if (capture) begin
        px_x   <= 8'(hoff >> SHIFT);
        px_y   <= 7'(voff >> SHIFT);
        px_rgb <= {vga_r, vga_g, vga_b};
      end
    end
  end

`ifdef CAPTURE_CRC_EN
  function automatic logic [15:0] crc_step(input logic [15:0] crc_in, input logic [23:0] data);
    logic [15:0] c;
    c = crc_in;
    for (int i = 23; i >= 0; i--)
      c = {c[14:0], 1'b0} ^ ((c[15] ^ data[i]) ? 16'h1021 : 16'h0000);
    return c;
  endfunction

  logic [15:0] crc_q;

  // The CRC restarts on the frame's first pixel so it tracks px_valid exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) crc_q <= '0;
    else if (capture) crc_q <= crc_step(origin ? 16'hFFFF : crc_q, {vga_r, vga_g, vga_b});
  end

  assign frame_crc = crc_q;
`else
  assign frame_crc = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_pixel_capture.sv
// tb_vga_pixel_capture: drives scaled-down VGA frames and checks every capture against a raster model.
// Checks frame_crc against a CRC model when CAPTURE_CRC_EN is defined, otherwise expects zero.
module tb_vga_pixel_capture;

  localparam int H_ACTIVE = 32, H_BP = 6, H_FP = 4, H_SYNC = 6;
  localparam int HT = H_BP + H_ACTIVE + H_FP + H_SYNC;
  localparam int V_ACTIVE = 16, V_BP = 3, V_FP = 2, VS_LINES = 3;
  localparam int LT = VS_LINES + V_BP + V_ACTIVE + V_FP;
  localparam int SCALE = 4;
  localparam int PX_W = H_ACTIVE / SCALE, PX_H = V_ACTIVE / SCALE;
  localparam int ERR_COLS = 20;

  logic        clk = 1'b0, rst = 1'b1;
  logic        vga_clk = 1'b0, vga_hs = 1'b1, vga_vs = 1'b1;
  logic [7:0]  vga_r = '0, vga_g = '0, vga_b = '0;
  logic        px_valid, frame_start, frame_done, sync_err;
  logic [7:0]  px_x;
  logic [6:0]  px_y;
  logic [23:0] px_rgb;
  logic [15:0] frame_crc;

  vga_pixel_capture #(
    .H_ACTIVE(H_ACTIVE), .H_BP(H_BP), .V_ACTIVE(V_ACTIVE), .V_BP(V_BP), .SCALE(SCALE)
  ) dut (
    .clk(clk), .rst(rst), .vga_clk(vga_clk), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .px_valid(px_valid), .px_x(px_x), .px_y(px_y), .px_rgb(px_rgb),
    .frame_start(frame_start), .frame_done(frame_done), .sync_err(sync_err),
    .frame_crc(frame_crc)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [7:0]  x;
    logic [6:0]  y;
    logic [23:0] rgb;
    bit          first;
    bit          done_after;
    logic [15:0] crc;
  } rec_t;

  rec_t        exp_q[$];
  int          errors = 0, checks = 0;
  int          n_valid = 0, n_start = 0, n_done = 0, n_nonblack = 0;
  logic [23:0] probe_rgb = '0;
  logic [15:0] model_crc = '0;
  bit          frozen = 1'b0;
  bit          exp_done = 1'b0;

  function automatic logic [23:0] pattern(input int pat, input int vx, input int vy);
    case (pat)
      0:       return 24'hFF0000;
      1:       return (vx >= 4 && vx <= 7 && vy >= 8 && vy <= 11) ? 24'h00FF00 : 24'h000000;
      default: return {8'(vx * 7 + 1), 8'(vy * 13 + 5), 8'(vx ^ vy)};
    endcase
  endfunction

  function automatic logic [15:0] crc_model(input logic [15:0] crc_in, input logic [23:0] data);
    logic [15:0] c;
    c = crc_in;
    for (int i = 23; i >= 0; i--) begin
      if (c[15] != data[i]) c = (c << 1) ^ 16'h1021;
      else c = c << 1;
    end
    return c;
  endfunction

  task automatic checkOutput(input string name, input logic [47:0] got, input logic [47:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Raster-order expectations for one frame: adapter pixel (x,y) carries the colour of VGA pixel (x*S, y*S).
  task automatic push_frame(input int pat, input int err_vy, input int stop_vy);
    rec_t        r;
    logic [15:0] crc;
    crc = 16'hFFFF;
    for (int y = 0; y < PX_H; y++) begin
      for (int x = 0; x < PX_W; x++) begin
        if (stop_vy >= 0 && y * SCALE >= stop_vy) continue;
        if (y * SCALE == err_vy && x * SCALE >= ERR_COLS) continue;
        r.x          = 8'(x);
        r.y          = 7'(y);
        r.rgb        = pattern(pat, x * SCALE, y * SCALE);
        r.first      = (x == 0 && y == 0);
        r.done_after = (x == PX_W - 1 && y == PX_H - 1 && err_vy < 0);
        crc          = crc_model(r.first ? 16'hFFFF : crc, r.rgb);
        r.crc        = crc;
        exp_q.push_back(r);
      end
    end
    model_crc = crc;
  endtask

  task automatic drive_pixel(input logic hs, input logic vs, input logic [23:0] rgb);
    @(posedge clk); #1;
    vga_clk = 1'b0;
    vga_hs  = hs;
    vga_vs  = vs;
    {vga_r, vga_g, vga_b} = rgb;
    @(posedge clk); #1;
    vga_clk = 1'b1;
  endtask

  task automatic freeze_clock();
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      vga_clk = 1'b0;
      vga_hs  = 1'($urandom_range(0, 1));
      vga_vs  = 1'($urandom_range(0, 1));
      if (i == 3) frozen = 1'b1;
      if (i == 998) frozen = 1'b0;
    end
  endtask

  task automatic reset_pulse();
    @(posedge clk); #3;
    rst = 1'b1;
    #2;
    checkOutput("reset_flags_xy", 48'({px_valid, frame_start, frame_done, sync_err, px_x, px_y}), 48'(0));
    checkOutput("reset_rgb_crc", 48'({px_rgb, frame_crc}), 48'(0));
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  // One frame: VS low from mid-line 0 to mid-line 2, then back porch, visible lines, front porch.
  task automatic applyStimulus(input int pat, input int err_vy, input int stop_vy, input int freeze_vy);
    int len, vy;
    logic hs, vs;
    for (int g = 0; g < LT; g++) begin
      vy  = g - VS_LINES - V_BP;
      len = (vy == err_vy) ? H_BP + ERR_COLS : HT;
      if (stop_vy >= 0 && vy == stop_vy) reset_pulse();
      for (int k = 0; k < len; k++) begin
        vs = !((g == 0 && k >= HT / 2) || g == 1 || (g == 2 && k < HT / 2));
        hs = (vy == err_vy) ? (k < len - 2) : (k < HT - H_SYNC);
        if (vy == freeze_vy && k == H_BP + 10) freeze_clock();
        if (vy >= 0 && vy < V_ACTIVE && k >= H_BP && k < H_BP + H_ACTIVE)
          drive_pixel(hs, vs, pattern(pat, k - H_BP, vy));
        else
          drive_pixel(hs, vs, 24'h000000);
      end
    end
  endtask

  task automatic resetCounts();
    n_valid    = 0;
    n_start    = 0;
    n_done     = 0;
    n_nonblack = 0;
    probe_rgb  = '0;
  endtask

  task automatic checkFrame(input string tag, input int want_valid, input int want_start,
                            input int want_done, input logic want_err, input logic [15:0] want_crc);
    checkOutput({tag, "_px_count"}, 48'(n_valid), 48'(want_valid));
    checkOutput({tag, "_start_count"}, 48'(n_start), 48'(want_start));
    checkOutput({tag, "_done_count"}, 48'(n_done), 48'(want_done));
    checkOutput({tag, "_sync_err"}, 48'(sync_err), 48'(want_err));
    checkOutput({tag, "_leftover"}, 48'(exp_q.size()), 48'(0));
`ifdef CAPTURE_CRC_EN
    checkOutput({tag, "_frame_crc"}, 48'(frame_crc), 48'(want_crc));
`else
    checkOutput({tag, "_frame_crc"}, 48'(frame_crc), 48'(want_crc & 16'h0000));
`endif
  endtask

  initial begin
    fork
      begin : compare
        rec_t r;
        bit   exp_start, done_next;
        forever begin
          @(negedge clk);
          if (rst) begin
            exp_done = 1'b0;
          end else begin
            exp_start = 1'b0;
            done_next = 1'b0;
            if (frozen) checkOutput("px_valid_frozen", 48'(px_valid), 48'(0));
            if (px_valid) begin
              n_valid++;
              if (exp_q.size() == 0) begin
                checkOutput("px_valid_unexpected", 48'(px_valid), 48'(0));
              end else begin
                r = exp_q.pop_front();
                checkOutput("pixel_xy_rgb", 48'({px_x, px_y, px_rgb}), 48'({r.x, r.y, r.rgb}));
                exp_start = r.first;
                done_next = r.done_after;
`ifdef CAPTURE_CRC_EN
                checkOutput("crc_running", 48'(frame_crc), 48'(r.crc));
`else
                checkOutput("crc_tied_zero", 48'(frame_crc), 48'(0));
`endif
              end
              if (px_x == 8'd1 && px_y == 7'd2) probe_rgb = px_rgb;
              if (px_rgb != 24'h0) n_nonblack++;
            end
            checkOutput("frame_start", 48'(frame_start), 48'(exp_start));
            checkOutput("frame_done", 48'(frame_done), 48'(exp_done));
            n_start += int'(frame_start);
            n_done  += int'(frame_done);
            exp_done = done_next;
          end
        end
      end
      begin : watchdog
        #5_000_000;
        errors++;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] timeout");
      end
    join_none

    repeat (4) @(posedge clk);
    #1;
    checkOutput("por_flags_xy", 48'({px_valid, frame_start, frame_done, sync_err, px_x, px_y}), 48'(0));
    checkOutput("por_rgb_crc", 48'({px_rgb, frame_crc}), 48'(0));
    #2;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) drive_pixel(1'b1, 1'b1, 24'h0);

    $display("[TB] solid red frame");
    resetCounts();
    push_frame(0, -1, -1);
    applyStimulus(0, -1, -1, -1);
    checkFrame("solid", 32, 1, 1, 1'b0, model_crc);

    $display("[TB] single green block");
    resetCounts();
    push_frame(1, -1, -1);
    applyStimulus(1, -1, -1, -1);
    checkFrame("green", 32, 1, 1, 1'b0, model_crc);
    checkOutput("green_px_1_2", 48'(probe_rgb), 48'h00FF00);
    checkOutput("green_nonblack_count", 48'(n_nonblack), 48'(1));

    $display("[TB] vga_clk stalled mid-line");
    resetCounts();
    push_frame(2, -1, -1);
    applyStimulus(2, -1, -1, 5);
    checkFrame("freeze", 32, 1, 1, 1'b0, model_crc);

    $display("[TB] same frame twice");
    for (int rep = 0; rep < 2; rep++) begin
      resetCounts();
      push_frame(2, -1, -1);
      applyStimulus(2, -1, -1, -1);
      checkFrame("repeat", 32, 1, 1, 1'b0, model_crc);
    end

    $display("[TB] early HS rise then two clean frames");
    resetCounts();
    push_frame(2, 8, -1);
    applyStimulus(2, 8, -1, -1);
    checkFrame("badhs", 29, 1, 0, 1'b1, model_crc);
    for (int rep = 0; rep < 2; rep++) begin
      resetCounts();
      push_frame(0, -1, -1);
      applyStimulus(0, -1, -1, -1);
      checkFrame("after_err", 32, 1, 1, 1'b1, model_crc);
    end

    $display("[TB] reset mid-frame then a clean frame");
    resetCounts();
    push_frame(2, -1, 6);
    applyStimulus(2, -1, 6, -1);
    checkFrame("midreset", 16, 1, 0, 1'b0, 16'h0000);
    resetCounts();
    push_frame(2, -1, -1);
    applyStimulus(2, -1, -1, -1);
    checkFrame("post_reset", 32, 1, 1, 1'b0, model_crc);

    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
